fetch_stage: RTL and testbench

Instruction fetch stage for the RV32I core. It owns the program counter, issues one word read at a time to instruction memory, and registers the returned instruction together with its PC. It presents that instruction to the decode/control logic and applies the PCSel redirect that the control logic computes for the instruction it consumes. Holds at most one outstanding memory request and two buffered instructions (output register plus skid entry).

---
 rtl/fetch_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Owns the program counter and keeps at most one word read outstanding to
// instruction memory. Returned instructions land in an output register, with
// one skid entry behind it for when decode is stalled. A consumed instruction
// may carry a PCSel redirect, which flushes everything fetched behind it.
// Optional feature macro: FETCH_ALIGN_CHK_EN. When it is defined, a redirect
// to a target that is not word aligned sets misalign_o and parks the stage in
// HALT until reset. When it is undefined, the target's low bits are dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PCSel_i,
  input  logic [31:0] alu_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        inst_valid_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_FULL = 3'd3
`ifdef FETCH_ALIGN_CHK_EN
    , ST_HALT = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;              // address of the next word to fetch
  logic        kill_q, kill_d;          // outstanding response belongs to a flushed path
  logic [31:0] inst_q, inst_d;          // output register: instruction
  logic [31:0] ipc_q, ipc_d;            // output register: its PC
  logic [31:0] pc4_q, pc4_d;            // output register: its PC + 4
  logic        valid_q, valid_d;        // output register holds an instruction
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        req_q, req_d;            // request strobe, high exactly while in REQ

  logic        consume_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  assign consume_s  = valid_q && !stall_i;
  assign redirect_s = consume_s && PCSel_i;
  assign target_s   = {alu_i[31:2], 2'b00};
  assign pc_inc_s   = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_q, misalign_d;
  logic misalign_s;

  assign misalign_s = redirect_s && (alu_i[1:0] != 2'b00);
`else
  // Target low bits are intentionally dropped in this build.
  logic unused_alu_lsb_s;

  assign unused_alu_lsb_s = ^alu_i[1:0];
`endif

  // Next-state logic: FSM transitions, PC update, output/skid register loads.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    inst_d      = inst_q;
    ipc_d       = ipc_q;
    valid_d     = valid_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
`ifdef FETCH_ALIGN_CHK_EN
    misalign_d  = misalign_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        // The request for pc_q leaves this cycle no matter what; a redirect
        // can only mark its response as stale.
        state_d = ST_WAIT;
        if (redirect_s) begin
          pc_d    = target_s;
          kill_d  = 1'b1;
          valid_d = 1'b0;
        end else if (consume_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid_i && kill_q) begin
          // Response to a flushed path: drop it and fetch from pc_q.
          kill_d  = 1'b0;
          state_d = ST_REQ;
          if (redirect_s) begin
            pc_d    = target_s;
            valid_d = 1'b0;
          end else if (consume_s) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else if (imem_rvalid_i && redirect_s) begin
          // Data arrives together with a redirect: it is already stale.
          pc_d    = target_s;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (imem_rvalid_i && (!valid_q || consume_s)) begin
          inst_d  = imem_rdata_i;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc_s;
          state_d = ST_REQ;
        end else if (imem_rvalid_i) begin
          // Output is held by a stall: park the word in the skid entry.
          skid_inst_d = imem_rdata_i;
          skid_pc_d   = pc_q;
          pc_d        = pc_inc_s;
          state_d     = ST_FULL;
        end else if (redirect_s) begin
          pc_d    = target_s;
          kill_d  = 1'b1;
          valid_d = 1'b0;
        end else if (consume_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end

      ST_FULL: begin
        // No request is outstanding here, so memory responses cannot occur.
        if (redirect_s) begin
          pc_d        = target_s;
          valid_d     = 1'b0;
          skid_inst_d = 32'd0;
          skid_pc_d   = 32'd0;
          state_d     = ST_REQ;
        end else if (consume_s) begin
          inst_d      = skid_inst_q;
          ipc_d       = skid_pc_q;
          valid_d     = 1'b1;
          skid_inst_d = 32'd0;
          skid_pc_d   = 32'd0;
          state_d     = ST_REQ;
        end else begin
          state_d = ST_FULL;
        end
      end

`ifdef FETCH_ALIGN_CHK_EN
      ST_HALT: begin
        // Terminal until reset; late responses are ignored.
        valid_d = 1'b0;
        state_d = ST_HALT;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        kill_d  = 1'b0;
      end
    endcase

`ifdef FETCH_ALIGN_CHK_EN
    // A misaligned redirect overrides every other transition.
    if (misalign_s) begin
      misalign_d  = 1'b1;
      state_d     = ST_HALT;
      valid_d     = 1'b0;
      kill_d      = 1'b0;
      pc_d        = pc_q;
      skid_inst_d = 32'd0;
      skid_pc_d   = 32'd0;
    end else begin
      misalign_d  = misalign_q;
    end
`endif

    req_d = (state_d == ST_REQ);
    pc4_d = ipc_d + 32'd4;
  end

  // State and output registers, cleared asynchronously by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      inst_q      <= 32'd0;
      ipc_q       <= 32'd0;
      pc4_q       <= 32'd4;
      valid_q     <= 1'b0;
      skid_inst_q <= 32'd0;
      skid_pc_q   <= 32'd0;
      req_q       <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      inst_q      <= inst_d;
      ipc_q       <= ipc_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      req_q       <= req_d;
`ifdef FETCH_ALIGN_CHK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign pc_o         = ipc_q;
  assign pc4_o        = pc4_q;
  assign inst_valid_o = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign misalign_o   = misalign_q;
`else
  assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized bench for fetch_stage.
// A memory model answers requests after a chosen latency; an architectural
// model checks that consumed instructions follow program order (PC+4 or the
// redirect target) and carry the memory word at their PC.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcsel;
  logic        stall;
  logic        rvalid;
  logic        req;
  logic        valid;
  logic        mis;
  logic [31:0] alu;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .PCSel_i      (pcsel),
    .alu_i        (alu),
    .stall_i      (stall),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .inst_o       (inst),
    .pc_o         (pc),
    .pc4_o        (pc4),
    .inst_valid_o (valid),
    .misalign_o   (mis)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  int          mem_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr, s_inst, s_pc, s_pc4;
  logic [31:0] exp_pc;
  int          idle_cnt;
  int          n_cons;

  // Instruction memory contents: distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1 ({tag, "_req"},   s_req,   1'b0);
    chk32({tag, "_addr"},  s_addr,  RST_PC);
    chk32({tag, "_inst"},  s_inst,  32'd0);
    chk32({tag, "_pc"},    s_pc,    32'd0);
    chk32({tag, "_pc4"},   s_pc4,   32'd4);
    chk1 ({tag, "_valid"}, s_valid, 1'b0);
    chk1 ({tag, "_mis"},   s_mis,   1'b0);
  endtask

  // One clock cycle: sample at negedge, run models, then update memory
  // response for the following cycle just after the posedge.
  task automatic cyc();
    @(negedge clk);
    s_req   = req;
    s_addr  = addr;
    s_valid = valid;
    s_inst  = inst;
    s_pc    = pc;
    s_pc4   = pc4;
    s_mis   = mis;
    if (!rst) begin
      if (s_req) begin
        chk1("req_while_outstanding", mem_busy, 1'b0);
        chk32("req_addr_aligned", {30'd0, s_addr[1:0]}, 32'd0);
        mem_busy = 1'b1;
        mem_cnt  = lat;
        mem_addr = s_addr;
      end
      if (s_valid) chk32("pc4_rel", s_pc4, s_pc + 32'd4);
      if (s_valid && !stall) begin
        chk32("sb_pc", s_pc, exp_pc);
        chk32("sb_inst", s_inst, mem_word(exp_pc));
        n_cons++;
        idle_cnt = 0;
        if (pcsel) exp_pc = {alu[31:2], 2'b00};
        else       exp_pc = exp_pc + 32'd4;
      end else begin
        idle_cnt++;
      end
    end else begin
      exp_pc   = RST_PC;
      idle_cnt = 0;
    end
    @(posedge clk);
    #1;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rvalid   = 1'b1;
        rdata    = mem_word(mem_addr);
        mem_busy = 1'b0;
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
      end
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; pcsel = 1'b0; stall = 1'b0; alu = 32'd0;
    rvalid = 1'b0; rdata = 32'd0; lat = 1;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'd0;
    exp_pc = RST_PC; idle_cnt = 0; n_cons = 0;

    // Reset state
    repeat (3) cyc();
    chk_reset("rst");

    // Reset fetch, latency 1
    rst = 1'b0;
    cyc();                                   // cycle 1
    chk1("c1_req", s_req, 1'b0);
    cyc();                                   // cycle 2
    chk1("c2_req", s_req, 1'b1);
    chk32("c2_addr", s_addr, 32'h0);
    cyc();                                   // cycle 3
    chk1("c3_valid", s_valid, 1'b0);
    stall = 1'b1;
    cyc();                                   // cycle 4
    chk1("c4_valid", s_valid, 1'b1);
    chk32("c4_inst", s_inst, 32'h0050_0093);
    chk32("c4_pc", s_pc, 32'h0);
    chk32("c4_pc4", s_pc4, 32'h4);
    chk1("c4_req", s_req, 1'b1);
    chk32("c4_addr", s_addr, 32'h4);

    // Stall: second response goes to the skid entry, no further requests
    cyc();                                   // cycle 5: rvalid for addr 4
    cyc();                                   // cycle 6
    chk1("full_req6", s_req, 1'b0);
    cyc();                                   // cycle 7
    chk1("full_req7", s_req, 1'b0);
    chk32("full_pc7", s_pc, 32'h0);
    lat = 3;
    stall = 1'b0;
    cyc();                                   // cycle 8: consume pc 0
    stall = 1'b1;
    cyc();                                   // cycle 9
    chk32("skid_pc", s_pc, 32'h4);
    chk32("skid_inst", s_inst, mem_word(32'h4));
    chk1("skid_req", s_req, 1'b1);
    chk32("skid_addr", s_addr, 32'h8);

    // Redirect in WAIT with latency 3
    stall = 1'b0; pcsel = 1'b1; alu = 32'h100;
    cyc();                                   // cycle 10
    pcsel = 1'b0; alu = 32'd0;
    cyc();                                   // cycle 11
    chk1("rdw_valid11", s_valid, 1'b0);
    lat = 1;
    cyc();                                   // cycle 12: stale rvalid
    chk1("rdw_valid12", s_valid, 1'b0);
    chk1("rdw_req12", s_req, 1'b0);
    cyc();                                   // cycle 13
    chk1("rdw_req13", s_req, 1'b1);
    chk32("rdw_addr13", s_addr, 32'h100);
    cyc();                                   // cycle 14

    // Redirect in REQ to the last word: wrap-around
    pcsel = 1'b1; alu = 32'hFFFF_FFFC;
    cyc();                                   // cycle 15
    chk32("rdw_pc15", s_pc, 32'h100);
    chk1("rdr_req15", s_req, 1'b1);
    chk32("rdr_addr15", s_addr, 32'h104);
    pcsel = 1'b0; alu = 32'd0;
    cyc();                                   // cycle 16: stale rvalid
    cyc();                                   // cycle 17
    chk1("wrap_req17", s_req, 1'b1);
    chk32("wrap_addr17", s_addr, 32'hFFFF_FFFC);
    cyc();                                   // cycle 18

    // Misaligned redirect
    pcsel = 1'b1; alu = 32'h102;
    cyc();                                   // cycle 19
    chk32("wrap_pc19", s_pc, 32'hFFFF_FFFC);
    chk32("wrap_pc4_19", s_pc4, 32'h0);
    chk1("wrap_req19", s_req, 1'b1);
    chk32("wrap_addr19", s_addr, 32'h0);
    pcsel = 1'b0; alu = 32'd0;
    cyc();                                   // cycle 20
`ifdef FETCH_ALIGN_CHK_EN
    for (int k = 0; k < 4; k++) begin
      chk1("halt_mis", s_mis, 1'b1);
      chk1("halt_req", s_req, 1'b0);
      chk1("halt_valid", s_valid, 1'b0);
      cyc();
    end
`else
    chk1("mis_tied", s_mis, 1'b0);
    cyc();                                   // cycle 21
    chk1("mal_req21", s_req, 1'b1);
    chk32("mal_addr21", s_addr, 32'h100);
    cyc();                                   // cycle 22
    cyc();                                   // cycle 23
    chk1("mal_valid23", s_valid, 1'b1);
    chk32("mal_pc23", s_pc, 32'h100);
`endif

    // Reset mid-operation while in WAIT
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0; lat = 3;
    cyc();                                   // R1
    cyc();                                   // R2
    chk1("rm_req2", s_req, 1'b1);
    chk32("rm_addr2", s_addr, 32'h0);
    rst = 1'b1;
    cyc();                                   // R3: reset inside WAIT
    chk_reset("rm");
    rst = 1'b0; lat = 1;
    cyc();                                   // R4
    chk1("rm_req4", s_req, 1'b0);
    cyc();                                   // R5: late rvalid while in REQ
    chk1("rm_req5", s_req, 1'b1);
    chk1("rm_valid5", s_valid, 1'b0);
    cyc();                                   // R6
    chk1("rm_valid6", s_valid, 1'b0);
    cyc();                                   // R7
    chk1("rm_valid7", s_valid, 1'b1);
    chk32("rm_inst7", s_inst, 32'h0050_0093);
    chk32("rm_pc7", s_pc, 32'h0);

    // Randomized traffic against the architectural model
    n_cons = 0;
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      pcsel = ($urandom_range(0, 9) < 2);
      r = $urandom;
      if (r[31:30] == 2'b00) alu = {28'hFFFF_FFF, r[3:0]};
      else                   alu = r;
`ifdef FETCH_ALIGN_CHK_EN
      alu[1:0] = 2'b00;
`endif
      lat = $urandom_range(1, 4);
      cyc();
      if (idle_cnt > 60) begin
        chk32("progress_timeout", 32'(idle_cnt), 32'd0);
        break;
      end
    end
    chk1("rand_progress", (n_cons >= 150), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
